// File: rtl/cache_mem_arbiter.sv
// Arbitrates the I-cache and D-cache line ports onto the single cacheline adaptor.
// Either round-robin or D-priority is used on ties, and one latched transaction is served at a time.
module cache_mem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned LINE_WIDTH = 256,
    parameter bit          D_PRIORITY = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] ic_address,
    input  logic                  ic_read,
    output logic [LINE_WIDTH-1:0] ic_rdata,
    output logic                  ic_resp,
    input  logic [ADDR_WIDTH-1:0] dc_address,
    input  logic                  dc_read,
    input  logic                  dc_write,
    input  logic [LINE_WIDTH-1:0] dc_wdata,
    output logic [LINE_WIDTH-1:0] dc_rdata,
    output logic                  dc_resp,
    output logic [ADDR_WIDTH-1:0] pm_address,
    output logic                  pm_read,
    output logic                  pm_write,
    output logic [LINE_WIDTH-1:0] pm_wdata,
    input  logic [LINE_WIDTH-1:0] pm_rdata,
    input  logic                  pm_resp,
    output logic                  busy,
    output logic                  owner
);

    typedef enum logic [1:0] {StIdle, StServeI, StServeD} state_e;

    state_e state;
    logic   last_grant;  // 1 = D-cache was granted most recently
    logic   req_i;
    logic   req_d;
    logic   grant_d;

    always_comb begin
        req_i = ic_read;
        req_d = dc_read | dc_write;
        if (req_i && req_d) begin
            grant_d = D_PRIORITY ? 1'b1 : ~last_grant;
        end else begin
            grant_d = req_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= StIdle;
            last_grant <= 1'b1;
            pm_address <= '0;
            pm_wdata   <= '0;
            pm_read    <= 1'b0;
            pm_write   <= 1'b0;
            busy       <= 1'b0;
            owner      <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (req_i || req_d) begin
                        busy       <= 1'b1;
                        owner      <= grant_d;
                        last_grant <= grant_d;
                        if (grant_d) begin
                            pm_address <= dc_address;
                            pm_wdata   <= dc_wdata;
                            // Illegal read+write resolves to the writeback.
                            pm_read    <= dc_read & ~dc_write;
                            pm_write   <= dc_write;
                            state      <= StServeD;
                        end else begin
                            pm_address <= ic_address;
                            pm_read    <= 1'b1;
                            pm_write   <= 1'b0;
                            state      <= StServeI;
                        end
                    end
                end
                StServeI, StServeD: begin
                    if (pm_resp) begin
                        pm_read  <= 1'b0;
                        pm_write <= 1'b0;
                        busy     <= 1'b0;
                        state    <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign ic_resp  = pm_resp & (state == StServeI);
    assign dc_resp  = pm_resp & (state == StServeD);
    assign ic_rdata = pm_rdata;
    assign dc_rdata = pm_rdata;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: a round-robin instance plus a D-priority instance
// on shared stimulus; inputs driven on the falling edge, outputs checked just after.
module tb_cache_mem_arbiter;

    localparam logic [255:0] L1 = {8{32'h1111_2222}};
    localparam logic [255:0] L2 = {8{32'h3333_4444}};
    localparam logic [255:0] L3 = {8{32'h5555_6666}};
    localparam logic [255:0] WB = {8{32'hAABB_CCDD}};

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [31:0]  ic_address = '0;
    logic         ic_read = 1'b0;
    logic [31:0]  dc_address = '0;
    logic         dc_read = 1'b0;
    logic         dc_write = 1'b0;
    logic [255:0] dc_wdata = '0;
    logic [255:0] pm_rdata = '0;
    logic         pm_resp = 1'b0;

    logic [255:0] ic_rdata, dc_rdata, pm_wdata;
    logic [31:0]  pm_address;
    logic         ic_resp, dc_resp, pm_read, pm_write, busy, owner;

    logic [255:0] p_ic_rdata, p_dc_rdata, p_pm_wdata;
    logic [31:0]  p_pm_address;
    logic         p_ic_resp, p_dc_resp, p_pm_read, p_pm_write, p_busy, p_owner;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    cache_mem_arbiter #(.ADDR_WIDTH(32), .LINE_WIDTH(256), .D_PRIORITY(1'b0)) dut (
        .clk(clk), .rst(rst),
        .ic_address(ic_address), .ic_read(ic_read), .ic_rdata(ic_rdata), .ic_resp(ic_resp),
        .dc_address(dc_address), .dc_read(dc_read), .dc_write(dc_write),
        .dc_wdata(dc_wdata), .dc_rdata(dc_rdata), .dc_resp(dc_resp),
        .pm_address(pm_address), .pm_read(pm_read), .pm_write(pm_write),
        .pm_wdata(pm_wdata), .pm_rdata(pm_rdata), .pm_resp(pm_resp),
        .busy(busy), .owner(owner)
    );

    cache_mem_arbiter #(.ADDR_WIDTH(32), .LINE_WIDTH(256), .D_PRIORITY(1'b1)) dut_p (
        .clk(clk), .rst(rst),
        .ic_address(ic_address), .ic_read(ic_read), .ic_rdata(p_ic_rdata),
        .ic_resp(p_ic_resp),
        .dc_address(dc_address), .dc_read(dc_read), .dc_write(dc_write),
        .dc_wdata(dc_wdata), .dc_rdata(p_dc_rdata), .dc_resp(p_dc_resp),
        .pm_address(p_pm_address), .pm_read(p_pm_read), .pm_write(p_pm_write),
        .pm_wdata(p_pm_wdata), .pm_rdata(pm_rdata), .pm_resp(pm_resp),
        .busy(p_busy), .owner(p_owner)
    );

    task automatic check_eq(input string tag, input logic [255:0] got,
                            input logic [255:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Grant was seen at the current falling edge; raise pm_resp lat cycles later.
    task automatic respond(input int lat, input logic [255:0] line);
        repeat (lat - 1) @(negedge clk);
        pm_resp  = 1'b1;
        pm_rdata = line;
        #1;
    endtask

    task automatic release_resp();
        @(negedge clk);
        pm_resp = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        ic_read = 1'b0; dc_read = 1'b0; dc_write = 1'b0; pm_resp = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_pm_read", pm_read, 0);
        check_eq("rst_pm_write", pm_write, 0);
        check_eq("rst_owner", owner, 0);
        check_eq("rst_pm_address", pm_address, 0);
        check_eq("rst_pm_wdata", pm_wdata, 0);

        // 1: I-only read, 12-cycle adaptor latency
        ic_address = 32'h0002_4680; ic_read = 1'b1;
        #1;
        check_eq("t1_pm_read_before_edge", pm_read, 0);
        tick();
        check_eq("t1_pm_read", pm_read, 1);
        check_eq("t1_pm_address", pm_address, 32'h0002_4680);
        check_eq("t1_owner", owner, 0);
        check_eq("t1_busy", busy, 1);
        respond(12, L1);
        check_eq("t1_ic_resp", ic_resp, 1);
        check_eq("t1_ic_rdata", ic_rdata, L1);
        check_eq("t1_dc_resp", dc_resp, 0);
        release_resp();
        ic_read = 1'b0;
        #1;
        check_eq("t1_ic_resp_one_cycle", ic_resp, 0);
        check_eq("t1_busy_done", busy, 0);
        check_eq("t1_pm_read_done", pm_read, 0);

        // 2: D writeback then D allocate read
        @(negedge clk);
        dc_address = 32'h0008_6500; dc_wdata = WB; dc_write = 1'b1;
        tick();
        check_eq("t2_pm_write", pm_write, 1);
        check_eq("t2_pm_read_wb", pm_read, 0);
        check_eq("t2_pm_wdata", pm_wdata, WB);
        check_eq("t2_pm_address_wb", pm_address, 32'h0008_6500);
        check_eq("t2_owner", owner, 1);
        respond(5, L3);
        check_eq("t2_dc_resp_wb", dc_resp, 1);
        check_eq("t2_ic_resp_wb", ic_resp, 0);
        release_resp();
        dc_write = 1'b0; dc_read = 1'b1; dc_address = 32'h0012_3420;
        #1;
        check_eq("t2_busy_gap", busy, 0);
        tick();
        check_eq("t2_pm_read", pm_read, 1);
        check_eq("t2_pm_write_rd", pm_write, 0);
        check_eq("t2_pm_address_rd", pm_address, 32'h0012_3420);
        respond(3, L2);
        check_eq("t2_dc_resp_rd", dc_resp, 1);
        check_eq("t2_dc_rdata", dc_rdata, L2);
        release_resp();
        dc_read = 1'b0;

        // 3: tie in round-robin; 4: same stimulus on the D-priority instance
        do_reset();
        ic_address = 32'h0000_1000; dc_address = 32'h0000_2000;
        ic_read = 1'b1; dc_read = 1'b1;
        tick();
        check_eq("t3_tie1_owner", owner, 0);
        check_eq("t3_tie1_addr", pm_address, 32'h0000_1000);
        check_eq("t4_tie1_owner", p_owner, 1);
        check_eq("t4_tie1_addr", p_pm_address, 32'h0000_2000);
        respond(2, L1);
        check_eq("t3_tie1_ic_resp", ic_resp, 1);
        check_eq("t3_tie1_dc_resp", dc_resp, 0);
        check_eq("t4_tie1_dc_resp", p_dc_resp, 1);
        release_resp();
        // both keep requesting: a second tie
        ic_address = 32'h0000_3000;
        tick();
        check_eq("t3_tie2_owner", owner, 1);
        check_eq("t3_tie2_addr", pm_address, 32'h0000_2000);
        check_eq("t4_tie2_owner", p_owner, 1);
        respond(2, L2);
        check_eq("t3_tie2_dc_resp", dc_resp, 1);
        release_resp();
        dc_read = 1'b0;
        tick();
        check_eq("t3_after_owner", owner, 0);
        check_eq("t4_after_owner", p_owner, 0);
        check_eq("t4_after_addr", p_pm_address, 32'h0000_3000);
        respond(2, L3);
        release_resp();
        ic_read = 1'b0;

        // 5: requester inputs change during SERVE_I
        do_reset();
        ic_address = 32'h0000_4440; ic_read = 1'b1;
        tick();
        check_eq("t5_grant_i", owner, 0);
        @(negedge clk);
        ic_address = 32'hDEAD_BEE0;
        dc_address = 32'h0000_5550; dc_wdata = WB; dc_write = 1'b1;
        tick();
        check_eq("t5_addr_held", pm_address, 32'h0000_4440);
        check_eq("t5_no_write", pm_write, 0);
        check_eq("t5_owner_held", owner, 0);
        respond(3, L1);
        check_eq("t5_ic_resp", ic_resp, 1);
        check_eq("t5_dc_stalled", dc_resp, 0);
        release_resp();
        ic_read = 1'b0;
        #1;
        check_eq("t5_idle_gap_busy", busy, 0);
        check_eq("t5_idle_gap_write", pm_write, 0);
        tick();
        check_eq("t5_d_write", pm_write, 1);
        check_eq("t5_d_owner", owner, 1);
        check_eq("t5_d_addr", pm_address, 32'h0000_5550);
        respond(2, L2);
        check_eq("t5_dc_resp", dc_resp, 1);
        release_resp();
        dc_write = 1'b0;

        // 6: async reset mid SERVE_D, then recovery and a stray pm_resp
        @(negedge clk);
        dc_address = 32'h0000_6660; dc_write = 1'b1;
        tick();
        check_eq("t6_pm_write", pm_write, 1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("t6_async_pm_write", pm_write, 0);
        check_eq("t6_async_busy", busy, 0);
        check_eq("t6_async_owner", owner, 0);
        @(negedge clk);
        rst = 1'b0; dc_write = 1'b0;
        @(negedge clk);
        ic_address = 32'h0000_7770; ic_read = 1'b1;
        tick();
        check_eq("t6_fresh_read", pm_read, 1);
        check_eq("t6_fresh_addr", pm_address, 32'h0000_7770);
        respond(4, L3);
        check_eq("t6_fresh_resp", ic_resp, 1);
        release_resp();
        ic_read = 1'b0;
        @(negedge clk);
        pm_resp = 1'b1;
        #1;
        check_eq("t6_stray_ic_resp", ic_resp, 0);
        check_eq("t6_stray_dc_resp", dc_resp, 0);
        tick();
        pm_resp = 1'b0;
        check_eq("t6_stray_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Shares the single cacheline-wide path to `cacheline_adaptor` between the L1 I-cache and the L1 D-cache of the multicycle OTTER.
- Each cache's downstream `mem_itf`-style port (address/read/write/rdata/wdata/resp) lands here. The arbiter grants one requester at a time, latches its request and drives one memory transaction. It then routes the response back to the owner.
- Default policy is round-robin on contention. An option gives the D-cache fixed priority.

Parameters:
- ADDR_WIDTH, 32, byte address width on all ports.
- LINE_WIDTH, 256, cacheline data width in bits.
- D_PRIORITY, 0, 0 = round-robin between I and D; 1 = D always wins ties.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- ic_address  in  ADDR_WIDTH  I-cache line address.
- ic_read  in  1  I-cache line read request.
- ic_rdata  out  LINE_WIDTH  line returned to I-cache.
- ic_resp  out  1  I-cache transaction done.
- dc_address  in  ADDR_WIDTH  D-cache line address.
- dc_read  in  1  D-cache line read (allocate).
- dc_write  in  1  D-cache line write (writeback).
- dc_wdata  in  LINE_WIDTH  writeback line.
- dc_rdata  out  LINE_WIDTH  line returned to D-cache.
- dc_resp  out  1  D-cache transaction done.
- pm_address  out  ADDR_WIDTH  address to adaptor.
- pm_read  out  1  read to adaptor.
- pm_write  out  1  write to adaptor.
- pm_wdata  out  LINE_WIDTH  write line to adaptor.
- pm_rdata  in  LINE_WIDTH  line from adaptor.
- pm_resp  in  1  adaptor done.
- busy  out  1  transaction outstanding.
- owner  out  1  0 = I-cache, 1 = D-cache; valid when busy.

Behaviour:
- States: IDLE, SERVE_I, SERVE_D.
- Reset (async, any state): state = IDLE; pm_read, pm_write, busy, owner, ic_resp, dc_resp = 0; pm_address, pm_wdata = 0; last_grant = D, so the first tie goes to I in round-robin mode.

IDLE:
- Requests: reqI = ic_read; reqD = dc_read | dc_write.
- On a clock edge with only reqI: latch ic_address, set pm_read = 1, pm_write = 0, owner = 0, go to SERVE_I.
- On an edge with only reqD: latch dc_address and dc_wdata, set pm_read = dc_read, pm_write = dc_write, owner = 1, go to SERVE_D.
- Both requesting:
  - D_PRIORITY = 1: grant D.
  - Otherwise: grant the requester that is not last_grant.
  - last_grant updates on every grant.
- dc_read and dc_write both high is illegal. If it occurs, the write is taken (pm_write = 1, pm_read = 0).
- Grant latency: pm_read/pm_write are registered and assert the cycle after the request is sampled.

SERVE_x:
- pm_* outputs hold their latched values, independent of requester inputs.
- busy = 1.
- The non-owner is stalled; its resp = 0.

Response path:
- ic_resp = pm_resp & SERVE_I and dc_resp = pm_resp & SERVE_D, both combinational. Same cycle as pm_resp.
- ic_rdata and dc_rdata are driven by pm_rdata at all times; data is only meaningful alongside resp.

Completion:
- On the edge where pm_resp = 1: clear pm_read/pm_write, busy = 0, return to IDLE.
- Exactly one resp cycle per transaction.
- No back-to-back grant on that edge. Requesters drop read/write the cycle after resp, per the mem_itf protocol. A request still high in IDLE is a new request.
- Minimum gap between consecutive memory transactions: 1 IDLE cycle.

Boundary conditions:
- Owner drops its request mid-transaction: the transaction completes unchanged and the resp pulse is still issued.
- pm_resp while IDLE: ignored, no resp to either cache.
- The D-cache writeback then allocate sequence is two independent transactions. In round-robin mode, a pending I read may be granted between them. This is legal because the dirty line is already written.
- Starvation bound: in round-robin mode, a continuously requesting cache waits at most one other transaction.

Test Plan:
1. I-only read 0x00024680, adaptor responds after 12 cycles with line L1 -> pm_read asserted 1 cycle after request, pm_address = 0x00024680, ic_resp high exactly 1 cycle with ic_rdata = L1, dc_resp stays 0.
2. D writeback to 0x00086500 with line 0xAABB..DD (all 32 bytes patterned), then D read 0x00123420 -> pm_write = 1 with matching pm_wdata first, then pm_read; two dc_resp pulses; busy drops between them for ≥1 cycle.
3. ic_read and dc_read raised the same cycle after reset, D_PRIORITY = 0 -> I served first (owner = 0), D second. Repeat the tie -> D first this time (alternation).
4. Same as 3 with D_PRIORITY = 1 -> D served first on every tie.
5. During SERVE_I, change ic_address to 0xDEADBEE0 and pulse dc_write -> pm_address unchanged. The D request is granted only after ic_resp and one IDLE cycle.
6. Assert rst asynchronously mid SERVE_D (between clock edges) -> pm_write, busy and owner go 0 immediately. After release, a fresh ic_read is granted normally. A stray pm_resp in IDLE produces no resp.
